// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue between the CPU fetch stage and the memory instruction port.
// It prefetches sequential words ahead of the CPU, and a CPU address that misses the queue head redirects fetching.
module fetch_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PF_LIMIT = 32'h0000_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_enable,
  output logic        cpu_valid,
  output logic [31:0] cpu_data,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  input  logic        mem_valid,
  input  logic [31:0] mem_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_BUSY = 2'd1,
    M_GAP  = 2'd2
  } mstate_t;

  logic [29:0]   r_q_addr [DEPTH];
  logic [31:0]   r_q_data [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pf_addr;
  logic          r_discard;
  mstate_t       r_state;

  logic          w_cpu_req;
  logic          w_in_flight;
  logic          w_hit;
  logic          w_pending;
  logic          w_miss;
  logic          w_return;
  logic          w_push;
  logic [31:0]   w_next_pf;
  logic [CW-1:0] w_count_eff;
  logic          w_issue;
  logic          w_unused;

  // cpu_enable is stale while cpu_valid is high, so requests are only seen outside that cycle
  assign w_cpu_req   = cpu_enable & ~cpu_valid;
  assign w_in_flight = (r_state == M_BUSY);
  assign w_hit       = w_cpu_req && (r_count != '0) && (r_q_addr[r_rd_ptr] == cpu_addr[31:2]);
  assign w_pending   = w_cpu_req && (r_count == '0) && w_in_flight && !r_discard &&
                       (mem_addr[31:2] == cpu_addr[31:2]);
  assign w_miss      = w_cpu_req && !w_hit && !w_pending;
  assign w_return    = w_in_flight && mem_valid;
  // A flush in the same cycle as a returning word drops that word
  assign w_push      = w_return && !r_discard && !w_miss;
  assign w_next_pf   = w_miss ? {cpu_addr[31:2], 2'b00} : r_pf_addr;
  assign w_count_eff = w_miss ? '0 : r_count;
  assign w_issue     = (r_state == M_IDLE) && (w_count_eff < CW'(DEPTH)) &&
                       ((w_next_pf <= PF_LIMIT) ||
                        (w_cpu_req && (w_next_pf[31:2] == cpu_addr[31:2])));
  assign w_unused    = ^cpu_addr[1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= mem_addr[31:2];
      r_q_data[r_wr_ptr] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      cpu_valid <= 1'b0;
      cpu_data  <= 32'd0;
    end else begin
      cpu_valid <= w_hit;
      if (w_hit) begin
        cpu_data <= r_q_data[r_rd_ptr];
      end
      if (w_miss) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_hit) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_hit);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= M_IDLE;
      mem_enable <= 1'b0;
      mem_addr   <= 32'd0;
      r_pf_addr  <= 32'd0;
      r_discard  <= 1'b0;
    end else begin
      // A word already returning this cycle is dropped directly, so it must not arm the flag
      if (w_miss && w_in_flight && !mem_valid) begin
        r_discard <= 1'b1;
      end else if (w_return) begin
        r_discard <= 1'b0;
      end
      if (w_issue) begin
        r_pf_addr <= w_next_pf + 32'd4;
      end else if (w_miss) begin
        r_pf_addr <= w_next_pf;
      end
      case (r_state)
        M_IDLE: begin
          if (w_issue) begin
            mem_addr   <= w_next_pf;
            mem_enable <= 1'b1;
            r_state    <= M_BUSY;
          end
        end
        M_BUSY: begin
          if (mem_valid) begin
            mem_enable <= 1'b0;
            r_state    <= M_GAP;
          end
        end
        M_GAP: begin
          r_state <= M_IDLE;
        end
        default: begin
          mem_enable <= 1'b0;
          r_state    <= M_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench: two queue instances (default and a low PF_LIMIT), each behind a 5-cycle memory model.
module tb_fetch_prefetch_queue;

  localparam int LAT = 5;

  logic        clk;
  logic        rst;
  logic [31:0] cpu_addr_a, cpu_data_a, mem_addr_a, mem_data_a;
  logic        cpu_enable_a, cpu_valid_a, mem_enable_a, mem_valid_a;
  logic [31:0] cpu_addr_b, cpu_data_b, mem_addr_b, mem_data_b;
  logic        cpu_enable_b, cpu_valid_b, mem_enable_b, mem_valid_b;

  logic        m_valid_a, m_valid_b, f_valid, mem_auto, clr_b;
  int          cnt_a, cnt_b;
  logic        prev_en_a, prev_en_b;
  int          issues_a, issues_b, bad20;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];
  int          errors, checks;

  fetch_prefetch_queue #(.DEPTH(4), .PF_LIMIT(32'h0000_FFFC)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr_a), .cpu_enable(cpu_enable_a), .cpu_valid(cpu_valid_a), .cpu_data(cpu_data_a),
    .mem_addr(mem_addr_a), .mem_enable(mem_enable_a), .mem_valid(mem_valid_a), .mem_data(mem_data_a)
  );

  fetch_prefetch_queue #(.DEPTH(4), .PF_LIMIT(32'h0000_000C)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr_b), .cpu_enable(cpu_enable_b), .cpu_valid(cpu_valid_b), .cpu_data(cpu_data_b),
    .mem_addr(mem_addr_b), .mem_enable(mem_enable_b), .mem_valid(mem_valid_b), .mem_data(mem_data_b)
  );

  // Memory word at address A is ~A
  assign mem_valid_a = m_valid_a | f_valid;
  assign mem_data_a  = ~mem_addr_a;
  assign mem_valid_b = m_valid_b;
  assign mem_data_b  = ~mem_addr_b;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst || !mem_auto) begin
      cnt_a <= 0; m_valid_a <= 1'b0;
    end else if (m_valid_a) begin
      cnt_a <= 0; m_valid_a <= 1'b0;
    end else if (mem_enable_a) begin
      if (cnt_a == LAT - 1) m_valid_a <= 1'b1;
      cnt_a <= cnt_a + 1;
    end else begin
      cnt_a <= 0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt_b <= 0; m_valid_b <= 1'b0;
    end else if (m_valid_b) begin
      cnt_b <= 0; m_valid_b <= 1'b0;
    end else if (mem_enable_b) begin
      if (cnt_b == LAT - 1) m_valid_b <= 1'b1;
      cnt_b <= cnt_b + 1;
    end else begin
      cnt_b <= 0;
    end
  end

  // Request log: one entry per rising mem_enable
  always @(posedge clk) begin
    prev_en_a <= mem_enable_a;
    prev_en_b <= mem_enable_b;
    if (mem_enable_a && !prev_en_a) begin
      issues_a = issues_a + 1;
      log_a.push_back(mem_addr_a);
    end
    if (clr_b) begin
      issues_b = 0;
      log_b.delete();
    end else if (mem_enable_b && !prev_en_b) begin
      issues_b = issues_b + 1;
      log_b.push_back(mem_addr_b);
    end
    if (cpu_valid_a && cpu_data_a == 32'hFFFF_FFDF) bad20 = bad20 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for cpu_valid, then drop enable for one cycle
  task automatic fetch(input bit use_b, input logic [31:0] addr, output int lat, output logic [31:0] data);
    if (use_b) begin cpu_addr_b = addr; cpu_enable_b = 1'b1; end
    else begin cpu_addr_a = addr; cpu_enable_a = 1'b1; end
    lat  = 0;
    data = 32'hxxxx_xxxx;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (use_b ? cpu_valid_b : cpu_valid_a) begin
        data = use_b ? cpu_data_b : cpu_data_a;
        break;
      end
    end
    cpu_enable_a = 1'b0;
    cpu_enable_b = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] at_b(input int idx);
    return (idx < log_b.size()) ? log_b[idx] : 32'hDEAD_DEAD;
  endfunction

  initial begin
    int          lat;
    int          idx20;
    logic [31:0] d;
    clk = 1'b0; rst = 1'b1; f_valid = 1'b0; mem_auto = 1'b1; clr_b = 1'b0;
    cpu_addr_a = 32'd0; cpu_enable_a = 1'b0; cpu_addr_b = 32'd0; cpu_enable_b = 1'b0;
    prev_en_a = 1'b0; prev_en_b = 1'b0;
    issues_a = 0; issues_b = 0; bad20 = 0; errors = 0; checks = 0;
    tick(); tick();
    chk("rst_cpu_valid", 32'(cpu_valid_a), 32'd0);
    chk("rst_cpu_data", cpu_data_a, 32'd0);
    chk("rst_mem_enable", 32'(mem_enable_a), 32'd0);
    chk("rst_mem_addr", mem_addr_a, 32'd0);
    chk("rst_count", 32'(u_dut_a.r_count), 32'd0);
    rst = 1'b0;

    // Cold miss: 5-cycle memory + 3
    fetch(1'b0, 32'h0000_0000, lat, d);
    chk("miss_lat", 32'(lat), 32'd8);
    chk("miss_data0", d, 32'hFFFF_FFFF);

    // CPU idle: queue fills to exactly 4 (0x4..0x10) and stops
    repeat (40) tick();
    chk("fill_count", 32'(u_dut_a.r_count), 32'd4);
    chk("fill_mem_enable", 32'(mem_enable_a), 32'd0);
    chk("fill_issues", 32'(issues_a), 32'd5);
    repeat (10) tick();
    chk("fill_issues_hold", 32'(issues_a), 32'd5);

    fetch(1'b0, 32'h0000_0006, lat, d);
    chk("hit4_lat", 32'(lat), 32'd1);
    chk("hit4_data", d, 32'hFFFF_FFFB);
    fetch(1'b0, 32'h0000_0008, lat, d);
    chk("hit8_lat", 32'(lat), 32'd1);
    chk("hit8_data", d, 32'hFFFF_FFF7);

    // Enable held through the cpu_valid cycle: exactly one pop
    cpu_addr_a = 32'h0000_000C; cpu_enable_a = 1'b1;
    tick();
    chk("hs_valid", 32'(cpu_valid_a), 32'd1);
    chk("hs_data", cpu_data_a, 32'hFFFF_FFF3);
    chk("hs_count", 32'(u_dut_a.r_count), 32'd1);
    tick();
    chk("hs_no_second_valid", 32'(cpu_valid_a), 32'd0);
    chk("hs_count_hold", 32'(u_dut_a.r_count), 32'd1);
    cpu_enable_a = 1'b0;

    // Redirect while 0x20 is in flight behind 0x14..0x1C
    repeat (40) tick();
    fetch(1'b0, 32'h0000_0010, lat, d);
    chk("hit10_lat", 32'(lat), 32'd1);
    chk("hit10_data", d, 32'hFFFF_FFEF);
    chk("inflight20_en", 32'(mem_enable_a), 32'd1);
    chk("inflight20_addr", mem_addr_a, 32'h0000_0020);
    fetch(1'b0, 32'h0000_0100, lat, d);
    chk("redir_data", d, 32'hFFFF_FEFF);
    idx20 = -1;
    for (int i = 0; i < log_a.size(); i++) if (log_a[i] == 32'h0000_0020) idx20 = i;
    chk("redir_next_addr", (idx20 >= 0 && idx20 + 1 < log_a.size()) ? log_a[idx20 + 1] : 32'hDEAD_DEAD,
        32'h0000_0100);
    chk("redir_20_dropped", 32'(bad20), 32'd0);

    // Reset while busy, then a stray mem_valid
    mem_auto = 1'b0;
    tick(); tick();
    chk("busy_en", 32'(mem_enable_a), 32'd1);
    chk("busy_addr", mem_addr_a, 32'h0000_0104);
    rst = 1'b1; clr_b = 1'b1;
    tick();
    chk("mrst_cpu_valid", 32'(cpu_valid_a), 32'd0);
    chk("mrst_cpu_data", cpu_data_a, 32'd0);
    chk("mrst_mem_enable", 32'(mem_enable_a), 32'd0);
    chk("mrst_mem_addr", mem_addr_a, 32'd0);
    chk("mrst_count", 32'(u_dut_a.r_count), 32'd0);
    rst = 1'b0; clr_b = 1'b0; f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    chk("late_valid_count", 32'(u_dut_a.r_count), 32'd0);
    tick();
    chk("late_valid_count2", 32'(u_dut_a.r_count), 32'd0);
    chk("late_valid_cpu", 32'(cpu_valid_a), 32'd0);
    mem_auto = 1'b1;

    // PF_LIMIT = 0x0C: speculation stops at 0x0C, MMIO fetched on demand
    fetch(1'b1, 32'h0000_0000, lat, d);
    chk("lim_data0", d, 32'hFFFF_FFFF);
    repeat (40) tick();
    chk("lim_count", 32'(u_dut_b.r_count), 32'd3);
    chk("lim_mem_enable", 32'(mem_enable_b), 32'd0);
    chk("lim_issues", 32'(issues_b), 32'd4);
    fetch(1'b1, 32'h0000_0004, lat, d);
    chk("lim_data4", d, 32'hFFFF_FFFB);
    fetch(1'b1, 32'h0000_0008, lat, d);
    chk("lim_data8", d, 32'hFFFF_FFF7);
    fetch(1'b1, 32'h0000_000C, lat, d);
    chk("lim_dataC", d, 32'hFFFF_FFF3);
    fetch(1'b1, 32'h8000_0000, lat, d);
    chk("mmio_data0", d, 32'h7FFF_FFFF);
    fetch(1'b1, 32'h8000_0004, lat, d);
    chk("mmio_data1", d, 32'h7FFF_FFFB);
    repeat (3) tick();
    chk("lim_total_issues", 32'(issues_b), 32'd6);
    chk("lim_last_spec", at_b(3), 32'h0000_000C);
    chk("mmio_addr0", at_b(4), 32'h8000_0000);
    chk("mmio_addr1", at_b(5), 32'h8000_0004);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Instruction prefetch buffer between the CPU fetch stage and the memory controller's instruction port.
- Presents the same enable/valid fetch handshake to the CPU, and drives the memory controller's instruction enable/valid port on the other side.
- Runs ahead sequentially and holds up to DEPTH words, so straight-line fetches complete in 1 cycle instead of a full memory round trip.
- A CPU address that does not match the queue head flushes the queue and restarts fetching at the new address.

Parameters:
- DEPTH, 4, number of queued instruction words; power of two, minimum 2.
- PF_LIMIT, 32'h0000_FFFC, highest word address that may be fetched speculatively. Addresses above it (MMIO/GPIO) are fetched only on demand.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_addr  in  32  fetch address from CPU; bits [1:0] ignored
- cpu_enable  in  1  fetch request, held high until cpu_valid is seen
- cpu_valid  out  1  one-cycle pulse: cpu_data holds the word at cpu_addr
- cpu_data  out  32  instruction word
- mem_addr  out  32  instruction address to memory controller; bits [1:0] always 0
- mem_enable  out  1  request to memory controller, held until mem_valid
- mem_valid  in  1  one-cycle pulse: mem_data valid
- mem_data  in  32  returned word

Behaviour:
- Reset values:
  - cpu_valid=0, cpu_data=0, mem_enable=0, mem_addr=0.
  - Queue empty, pf_addr=0, no fetch in flight, discard flag clear.
- Queue: circular FIFO of {word address [31:2], data}. Read/write pointers wrap modulo DEPTH, plus a count 0..DEPTH.
- Addresses are compared on bits [31:2] only.
- CPU side, evaluated every cycle in which cpu_enable=1 and cpu_valid=0:
  - Hit (count>0 and head address == cpu_addr): pop the head. Next cycle cpu_valid=1 and cpu_data=head data. Hit latency is 1 cycle.
  - Pending (queue empty, in-flight fetch not discarded, in-flight address == cpu_addr): no action; wait.
  - Miss (any other case): clear the queue (count=0). If a fetch is in flight, set the discard flag. Set pf_addr=cpu_addr.
  - cpu_enable is ignored in the cycle cpu_valid=1, because the CPU's enable is stale there. cpu_valid is never high on two consecutive cycles.
- Memory-side FSM:
  - M_IDLE: issue when count + in_flight < DEPTH, and either pf_addr <= PF_LIMIT or pf_addr == cpu_addr with cpu_enable=1 (demand).
    - On issue: mem_addr <= {pf_addr[31:2],2'b00}, mem_enable <= 1, pf_addr <= pf_addr+4, go to M_BUSY.
  - M_BUSY: hold mem_enable and mem_addr stable.
    - On mem_valid: mem_enable <= 0, go to M_GAP.
    - If the discard flag is clear, push {in-flight address, mem_data}; otherwise drop the word and clear the flag.
  - M_GAP: one mandatory idle cycle, then M_IDLE.
- Miss latency: at least (memory latency + 3) cycles from the miss cycle to cpu_valid.
- Boundary conditions:
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Miss and mem_valid in the same cycle: the flush wins and the returning word is discarded.
  - The issue rule guarantees the queue is never full when a word returns, so overflow is impossible.
  - pf_addr wraps from 32'hFFFF_FFFC to 0 with no special handling.
  - Speculative fetching stops at PF_LIMIT. Demand fetches above PF_LIMIT proceed one word at a time.
  - rst while M_BUSY: everything returns to reset values. A late mem_valid is ignored while in M_IDLE.

Test Plan:
- Sequential fetch: after reset, CPU requests 0x0,0x4,0x8,0xC with a 5-cycle-latency memory model -> first cpu_valid after the miss latency; later requests return cpu_valid exactly 1 cycle after enable, with correct data.
- Fill limit: CPU idle after one fetch, DEPTH=4 -> exactly 4 words queued, mem_enable stays 0, no further requests issued.
- Redirect: queue holds 0x10..0x1C, CPU requests 0x100 while 0x20 is in flight -> 0x20 is discarded and never delivered, the next mem_addr is 0x100, and cpu_data is the word at 0x100.
- PF_LIMIT: PF_LIMIT=0x0C, sequential run -> no mem_addr above 0x0C issued speculatively; a CPU request at 0x8000_0000 is still fetched on demand.
- Handshake: hold cpu_enable high on the cpu_valid cycle -> no second pop, count decrements by exactly 1.
- Reset mid-fetch: assert rst while M_BUSY, then pulse mem_valid -> all outputs 0, queue empty, nothing pushed.
